nios_rom_arbiter: RTL

Two-master arbiter placed in front of the Nios on-chip program memory (single-port, 2560 x 32-bit, 12-bit word address, 1-cycle read latency). It shares the single memory port between the CPU instruction/data master (m0, read-only) and the firmware loader/debug master (m1, read/write). It applies weighted round-robin scheduling, routes read data back to the issuing master, gates writes behind an unlock input, and rejects out-of-range addresses.

---
 rtl/nios_rom_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/nios_rom_arbiter.sv
// Two-master weighted round-robin arbiter in front of the single-port Nios program memory.
// m0 is the read-only CPU master; m1 is the loader/debug master whose writes are gated by wr_unlock.
module nios_rom_arbiter #(
    parameter int DEPTH     = 2560,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int M0_WEIGHT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    input  logic                  wr_unlock,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic                  mem_debugaccess,
    output logic                  mem_clken,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic [DATA_W-1:0]     mem_writedata,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic [15:0]           oob_count,
    output logic [15:0]           wr_blocked_count
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L  = DEPTH[ADDR_W:0];
    localparam logic [3:0]      WEIGHT_L = M0_WEIGHT[3:0];

    logic              m0_req, m1_req, m1_is_wr;
    logic              gnt0, gnt1, gnt_any, addr_ok;
    logic [ADDR_W-1:0] gnt_addr;
    logic              rdv0, rdv1;
    logic [DATA_W-1:0] ret_data;

    logic [3:0]        run_cnt_q, run_cnt_d;
    logic              pend_valid_q, pend_valid_d;
    logic              pend_owner_q, pend_owner_d;
    logic              pend_oob_q, pend_oob_d;
    logic [15:0]       oob_cnt_q, oob_cnt_d;
    logic [15:0]       blk_cnt_q, blk_cnt_d;
    logic [DATA_W-1:0] m0_hold_q, m0_hold_d;
    logic [DATA_W-1:0] m1_hold_q, m1_hold_d;

    always_comb begin
        // Requests are masked during reset so nothing is granted and waitrequests stay high.
        m0_req   = m0_read & ~reset;
        m1_req   = (m1_read | m1_write) & ~reset;
        m1_is_wr = m1_write & ~m1_read;

        gnt0     = m0_req & (~m1_req | (run_cnt_q < WEIGHT_L));
        gnt1     = m1_req & ~gnt0;
        gnt_any  = gnt0 | gnt1;
        gnt_addr = gnt1 ? m1_address : m0_address;
        addr_ok  = {1'b0, gnt_addr} < DEPTH_L;

        // run_cnt only counts m0 grants made while m1 is kept waiting.
        run_cnt_d = (m1_req & gnt0) ? run_cnt_q + 4'd1 : 4'd0;

        m0_waitrequest  = ~gnt0;
        m1_waitrequest  = ~gnt1;

        mem_clken       = 1'b1;
        mem_address     = '0;
        mem_chipselect  = 1'b0;
        mem_write       = 1'b0;
        mem_debugaccess = 1'b0;
        mem_byteenable  = '0;
        mem_writedata   = '0;
        if (gnt_any && addr_ok) begin
            mem_chipselect = 1'b1;
            mem_address    = gnt_addr;
            if (gnt1 && m1_is_wr) begin
                mem_write       = wr_unlock;
                mem_debugaccess = wr_unlock;
                mem_byteenable  = m1_byteenable;
                mem_writedata   = m1_writedata;
            end else begin
                mem_byteenable  = {BE_W{1'b1}};
            end
        end

        oob_cnt_d = oob_cnt_q;
        if (gnt_any && !addr_ok && oob_cnt_q != 16'hFFFF)
            oob_cnt_d = oob_cnt_q + 16'd1;
        blk_cnt_d = blk_cnt_q;
        if (gnt1 && m1_is_wr && addr_ok && !wr_unlock && blk_cnt_q != 16'hFFFF)
            blk_cnt_d = blk_cnt_q + 16'd1;

        // Writes never produce a return; out-of-range reads return zero.
        pend_valid_d = gnt0 | (gnt1 & ~m1_is_wr);
        pend_owner_d = gnt1;
        pend_oob_d   = ~addr_ok;

        rdv0     = pend_valid_q & ~pend_owner_q & ~reset;
        rdv1     = pend_valid_q &  pend_owner_q & ~reset;
        ret_data = pend_oob_q ? '0 : mem_readdata;

        m0_hold_d = rdv0 ? ret_data : m0_hold_q;
        m1_hold_d = rdv1 ? ret_data : m1_hold_q;

        m0_readdatavalid = rdv0;
        m1_readdatavalid = rdv1;
        m0_readdata      = reset ? '0 : m0_hold_d;
        m1_readdata      = reset ? '0 : m1_hold_d;
        oob_count        = oob_cnt_q;
        wr_blocked_count = blk_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_owner_q <= 1'b0;
            pend_oob_q   <= 1'b0;
            oob_cnt_q    <= '0;
            blk_cnt_q    <= '0;
            m0_hold_q    <= '0;
            m1_hold_q    <= '0;
        end else begin
            run_cnt_q    <= run_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_owner_q <= pend_owner_d;
            pend_oob_q   <= pend_oob_d;
            oob_cnt_q    <= oob_cnt_d;
            blk_cnt_q    <= blk_cnt_d;
            m0_hold_q    <= m0_hold_d;
            m1_hold_q    <= m1_hold_d;
        end
    end
endmodule
